// File: rtl/ft_add_sched.sv
// ft_add_sched: round-robin scheduler sharing one TMR 3-bit adder
// between two requesters, with retry, error count and sticky fault.
module ft_add_sched #(
  parameter int ADD_LAT   = 1,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [5:0]       req_a,
  input  logic [5:0]       req_b,
  input  logic [1:0]       req_par,
  input  logic [5:0]       req_op,
  output logic [1:0]       rsp_valid,
  output logic [2:0]       rsp_sum,
  output logic             rsp_cout,
  output logic [1:0]       rsp_status,
  output logic [2:0]       add_a,
  output logic [2:0]       add_b,
  output logic             add_par,
  output logic [2:0]       add_c,
  output logic             add_en,
  input  logic [2:0]       add_sum,
  input  logic             add_cout,
  input  logic [1:0]       add_err,
  output logic             fault,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int LW = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [LW-1:0] LAT  = LW'(ADD_LAT);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_REJ  = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_WAIT, S_RESP
  } state_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       par;
    logic [2:0] op;
  } op_t;

  state_t         state_q, state_d;
  logic           ptr_q, gnt_q, gnt_sel;
  op_t            op_q, op_sel;
  logic [LW-1:0]  wcnt_q;
  logic [RW-1:0]  rty_q;
  logic           accept, bad, smp, good, fail_set;

  always_comb begin
    gnt_sel = ptr_q;
    if (req_valid == 2'b01) gnt_sel = 1'b0;
    else if (req_valid == 2'b10) gnt_sel = 1'b1;
  end

  // ready is gated by rst_n so it reads 0 while reset is held
  assign accept    = rst_n && (state_q == S_IDLE) && (|req_valid);
  assign req_ready = accept ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;

  assign op_sel = gnt_sel
    ? '{req_a[5:3], req_b[5:3], req_par[1], req_op[5:3]}
    : '{req_a[2:0], req_b[2:0], req_par[0], req_op[2:0]};

  assign bad = !(^{op_q.a, op_q.b, op_q.par}) ||
               !((op_q.op == 3'b001) || (op_q.op == 3'b010) ||
                 (op_q.op == 3'b100));

  assign smp      = (state_q == S_WAIT) && (wcnt_q == LW'(1));
  assign good     = (add_err == 2'b10);
  assign fail_set = smp && !good && (rty_q == RMAX);

  assign add_en    = (state_q == S_WAIT);
  assign rsp_valid = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01)
                                         : 2'b00;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_CHECK;
      S_CHECK: state_d = (bad || fault) ? S_RESP : S_WAIT;
      S_WAIT:  if (smp && (good || rty_q == RMAX)) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      op_q       <= '0;
      wcnt_q     <= '0;
      rty_q      <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_status <= ST_OK;
      add_a      <= '0;
      add_b      <= '0;
      add_par    <= 1'b0;
      add_c      <= '0;
      fault      <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_sel;
        gnt_q <= gnt_sel;
        ptr_q <= ~gnt_sel;
      end
      if (state_q == S_CHECK) begin
        if (bad) begin
          rsp_status <= ST_REJ;
        end else if (fault) begin
          rsp_status <= ST_FAIL;
        end else begin
          add_a   <= op_q.a;
          add_b   <= op_q.b;
          add_par <= op_q.par;
          add_c   <= op_q.op;
          wcnt_q  <= LAT;
          rty_q   <= '0;
        end
      end
      if (state_q == S_WAIT) begin
        if (!smp) begin
          wcnt_q <= wcnt_q - LW'(1);
        end else if (good) begin
          rsp_sum    <= add_sum;
          rsp_cout   <= add_cout;
          rsp_status <= ST_OK;
        end else begin
          if (~&err_cnt) err_cnt <= err_cnt + CNT_W'(1);
          wcnt_q <= LAT;
          if (rty_q == RMAX) begin
            rsp_sum    <= add_sum;
            rsp_cout   <= add_cout;
            rsp_status <= ST_FAIL;
          end else begin
            rty_q <= rty_q + RW'(1);
          end
        end
      end
      if (fail_set) fault <= 1'b1;
      else if (clr_fault) fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ft_add_sched.sv
// tb_ft_add_sched: table vectors, corner sequences and random ops
// checked against a transaction-level model of the scheduler.
module tb_ft_add_sched;

  localparam int LAT  = 1;
  localparam int MAXR = 2;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, req_par;
  logic [5:0]    req_a, req_b, req_op;
  logic [1:0]    rsp_valid, rsp_status, add_err;
  logic [2:0]    rsp_sum, add_a, add_b, add_c, add_sum;
  logic          rsp_cout, add_par, add_en, add_cout, fault, clr_fault;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  ft_add_sched #(.ADD_LAT(LAT), .MAX_RETRY(MAXR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_par(req_par), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_status(rsp_status),
    .add_a(add_a), .add_b(add_b), .add_par(add_par), .add_c(add_c),
    .add_en(add_en), .add_sum(add_sum), .add_cout(add_cout),
    .add_err(add_err), .fault(fault), .clr_fault(clr_fault),
    .err_cnt(err_cnt)
  );

  typedef struct {
    int         port;
    logic [2:0] a;
    logic [2:0] b;
    logic       par;
    logic [2:0] op;
    int         ne;
    logic [2:0] sm;
    logic       co;
    logic [1:0] st;
    int         off;
    int         en;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int nsmp = 0;
  int err_until = 0;
  logic [1:0] bad_code = 2'b00;

  int   m_err = 0;
  logic m_fault = 1'b0;
  logic [2:0] m_sum = '0;
  logic m_co = 1'b0;

  function automatic logic [3:0] res(logic [2:0] a, logic [2:0] b,
                                     logic [2:0] op);
    case (op)
      3'b010:  return {1'b0, a} + {1'b0, ~b} + 4'd1;
      3'b100:  return {1'b0, ~a} + {1'b0, b} + 4'd1;
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  // adder model: correct sum, error code while samples < err_until
  logic [3:0] add_v;
  assign add_v    = res(add_a, add_b, add_c);
  assign add_sum  = add_v[2:0];
  assign add_cout = add_v[3];
  assign add_err  = (nsmp < err_until) ? bad_code : 2'b10;

  always @(posedge clk) if (add_en) nsmp <= nsmp + 1;

  wire [29:0] outs = {req_ready, rsp_valid, rsp_sum, rsp_cout,
                      rsp_status, add_a, add_b, add_par, add_c,
                      add_en, fault, err_cnt};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(inout vec_t v);
    logic [3:0] r;
    logic ok_par, ok_op;
    ok_par = ^{v.a, v.b, v.par};
    ok_op  = (v.op == 3'b001) || (v.op == 3'b010) || (v.op == 3'b100);
    v.sm = m_sum;
    v.co = m_co;
    v.off = 2;
    v.en = 0;
    if (!ok_par || !ok_op) begin
      v.st = 2'b01;
    end else if (m_fault) begin
      v.st = 2'b10;
    end else begin
      r = res(v.a, v.b, v.op);
      v.sm = r[2:0];
      v.co = r[3];
      v.st = (v.ne <= MAXR) ? 2'b00 : 2'b10;
      v.en = (v.ne <= MAXR) ? v.ne + 1 : MAXR + 1;
      v.off = 2 + LAT * v.en;
    end
  endtask

  task automatic do_op(input vec_t v);
    logic [1:0] pm;
    int n0, n, k;
    pm = (v.port == 1) ? 2'b10 : 2'b01;
    k = $urandom_range(0, 2);
    bad_code = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b11);
    err_until = nsmp + v.ne;
    n0 = nsmp;
    req_a = 6'($urandom);
    req_b = 6'($urandom);
    req_op = 6'($urandom);
    req_par = 2'($urandom);
    if (v.port == 1) begin
      req_a[5:3] = v.a; req_b[5:3] = v.b;
      req_op[5:3] = v.op; req_par[1] = v.par;
    end else begin
      req_a[2:0] = v.a; req_b[2:0] = v.b;
      req_op[2:0] = v.op; req_par[0] = v.par;
    end
    req_valid = pm;
    #1;
    chk("ready", req_ready, pm);
    step();
    req_valid = 2'b00;
    req_a = 6'($urandom);
    req_b = 6'($urandom);
    n = 0;
    while (rsp_valid == 2'b00 && n < 30) begin
      step();
      n++;
    end
    chk("latency", n + 1, v.off);
    chk("rsp_port", rsp_valid, pm);
    chk("rsp_sum", rsp_sum, v.sm);
    chk("rsp_cout", rsp_cout, v.co);
    chk("rsp_status", rsp_status, v.st);
    chk("add_en_cycles", nsmp - n0, v.en);
    if (v.st == 2'b00) m_err += v.en - 1;
    else if (v.st == 2'b10) m_err += v.en;
    if (m_err > 255) m_err = 255;
    if (v.st == 2'b10 && v.en > 0) m_fault = 1'b1;
    m_sum = v.sm;
    m_co = v.co;
    chk("err_cnt", err_cnt, m_err);
    chk("fault", fault, m_fault);
    step();
    chk("rsp_pulse", rsp_valid, 2'b00);
    chk("rsp_hold", {rsp_sum, rsp_cout, rsp_status}, {v.sm, v.co, v.st});
  endtask

  task automatic clr_pulse();
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    m_fault = 1'b0;
    chk("clr_fault", fault, 1'b0);
  endtask

  vec_t tbl [8];
  vec_t v;

  initial begin
    int n, r;
    logic [1:0] exp;
    tbl[0] = '{0, 3'd3, 3'd2, 1'b0, 3'b001, 0, 3'd5, 1'b0, 2'b00, 3, 1};
    tbl[1] = '{1, 3'd3, 3'd2, 1'b0, 3'b010, 0, 3'd1, 1'b1, 2'b00, 3, 1};
    tbl[2] = '{1, 3'd3, 3'd2, 1'b1, 3'b010, 0, 3'd1, 1'b1, 2'b01, 2, 0};
    tbl[3] = '{0, 3'd7, 3'd1, 1'b1, 3'b100, 0, 3'd2, 1'b0, 2'b00, 3, 1};
    tbl[4] = '{0, 3'd1, 3'd0, 1'b0, 3'b011, 0, 3'd2, 1'b0, 2'b01, 2, 0};
    tbl[5] = '{1, 3'd3, 3'd2, 1'b0, 3'b001, 1, 3'd5, 1'b0, 2'b00, 4, 2};
    tbl[6] = '{0, 3'd3, 3'd2, 1'b0, 3'b001, 3, 3'd5, 1'b0, 2'b10, 5, 3};
    tbl[7] = '{1, 3'd1, 3'd1, 1'b1, 3'b001, 0, 3'd5, 1'b0, 2'b10, 2, 0};

    rst_n = 1'b0;
    clr_fault = 1'b0;
    req_valid = 2'b11;
    req_a = {3'd1, 3'd1};
    req_b = 6'd0;
    req_par = 2'b00;
    req_op = {3'b001, 3'b001};
    repeat (2) step();
    chk("reset_outs", outs, 30'd0);
    rst_n = 1'b1;
    #1;

    // both ports requesting continuously: grants alternate from port 0
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1) ? 2'b10 : 2'b01;
      n = 0;
      while (req_ready == 2'b00 && n < 10) begin
        step();
        n++;
      end
      chk("alt_grant", req_ready, exp);
      step();
      chk("busy_ready", req_ready, 2'b00);
      n = 0;
      while (rsp_valid == 2'b00 && n < 10) begin
        step();
        n++;
      end
      chk("alt_rsp", rsp_valid, exp);
      chk("alt_status", rsp_status, 2'b00);
    end
    req_valid = 2'b00;
    step();

    for (int i = 0; i < 8; i++) do_op(tbl[i]);

    clr_pulse();
    v = '{0, 3'd5, 3'd4, 1'b0, 3'b001, 0, 3'd0, 1'b0, 2'b00, 0, 0};
    predict(v);
    do_op(v);

    // fault set and clear in the same cycle: set wins
    clr_fault = 1'b1;
    v = '{1, 3'd6, 3'd3, 1'b1, 3'b010, 3, 3'd0, 1'b0, 2'b00, 0, 0};
    predict(v);
    do_op(v);
    clr_fault = 1'b0;
    m_fault = 1'b0;
    chk("clr_after_set", fault, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (m_fault && $urandom_range(0, 3) != 0) clr_pulse();
      v.port = $urandom_range(0, 1);
      v.a = 3'($urandom);
      v.b = 3'($urandom);
      v.par = 1'($urandom);
      r = $urandom_range(0, 3);
      v.op = (r == 3) ? 3'($urandom) : (3'b001 << r);
      v.ne = $urandom_range(0, 3);
      predict(v);
      do_op(v);
      r = $urandom_range(0, 2);
      repeat (r) step();
    end

    // reset in the middle of WAIT
    if (m_fault) clr_pulse();
    err_until = nsmp;
    req_a = {3'd1, 3'd1};
    req_b = 6'd0;
    req_par = 2'b00;
    req_op = {3'b001, 3'b001};
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    step();
    chk("wait_add_en", add_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs, 30'd0);
    n = 0;
    repeat (3) begin
      step();
      if (rsp_valid != 2'b00) n++;
    end
    chk("rst_no_rsp", n, 0);
    chk("rst_hold_outs", outs, 30'd0);
    rst_n = 1'b1;
    err_until = nsmp;
    #1;
    chk("rst_ptr_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 10) begin
      step();
      n++;
    end
    chk("rst_after_rsp", rsp_valid, 2'b01);
    chk("rst_after_sum", rsp_sum, 3'd1);
    chk("rst_after_cnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft_add_sched.md
# ft_add_sched

Scheduler that shares one TMR-protected 3-bit adder between two requesters. It accepts one operation at a time through round-robin arbitration and pre-checks operand parity and the one-hot op code. It drives the adder, samples its result and error code, retries on adder-reported errors, and returns a per-requester response. A sticky fault flag puts the block into degraded mode after repeated adder failures.

## Interface
- ADD_LAT, 1: cycles the adder output needs to settle after operands change; must be >= 1
- MAX_RETRY, 2: re-samples allowed after an adder error before the operation is declared FAIL
- CNT_W, 8: width of the saturating adder-error counter
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-port request valid (bit g = port g)
- req_ready  out  2  per-port accept strobe; accept when req_valid[g] & req_ready[g]
- req_a  in  6  operand A, {port1[2:0], port0[2:0]}
- req_b  in  6  operand B, same packing as req_a
- req_par  in  2  per-port parity bit
- req_op  in  6  per-port one-hot op {C2,C1,C0}: C0 = A+B, C1 = A+~B+1, C2 = ~A+B+1
- rsp_valid  out  2  one-cycle response pulse to the granted port
- rsp_sum  out  3  result sum
- rsp_cout  out  1  result carry
- rsp_status  out  2  00 OK, 01 REJECT (bad parity/op), 10 FAIL (adder error or degraded)
- add_a, add_b  out  3 each  operands to the adder
- add_par  out  1  parity to the adder
- add_c  out  3  {C2,C1,C0} to the adder
- add_en  out  1  high while the adder result is being awaited
- add_sum  in  3  adder sum
- add_cout  in  1  adder carry
- add_err  in  2  adder code {XE1,XE0}; 2'b10 = good, anything else = error
- fault  out  1  sticky degraded-mode flag
- clr_fault  in  1  pulse; clears fault
- err_cnt  out  CNT_W  saturating count of adder-reported errors

## Operation
- States:
  - IDLE: req_ready = grant when any req_valid is high; otherwise 0.
  - On accept: latch the port's operands, par, op and the grant index; go to CHECK.
- Arbitration:
  - Pointer resets to port 0.
  - One valid request: grant it.
  - Both valid: grant the pointer port.
  - After any accept, pointer = other port.
- CHECK (one cycle):
  - If parity (A^B^par reduction) is even, or op is not exactly one-hot: status REJECT, go to RESP.
  - Else if fault=1: status FAIL, go to RESP. The adder is not driven in either case.
  - Else drive add_a/add_b/add_par/add_c from the latched values, load the wait counter with ADD_LAT, clear the retry count, and go to WAIT.
- WAIT:
  - add_en=1; decrement the counter each cycle.
  - On the cycle the counter reaches 1, sample add_sum, add_cout and add_err.
  - add_err==2'b10: capture sum/cout, status OK, go to RESP.
  - Error with retry < MAX_RETRY: retry++, err_cnt++, reload the counter, stay in WAIT.
  - Error with retry == MAX_RETRY: err_cnt++, status FAIL, set fault, go to RESP. rsp_sum/rsp_cout capture the last sampled values.
- RESP: rsp_valid[grant]=1 for one cycle; go to IDLE.
- Response data hold value until the next RESP.
- err_cnt saturates at all ones.
- fault is set only by a FAIL from WAIT. clr_fault clears it; if set and clear occur in the same cycle, set wins.
- add_a/add_b/add_par/add_c hold their last driven values outside WAIT. add_en=0 outside WAIT.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_status=00, add_* outputs=0, add_en=0, fault=0, err_cnt=0, state IDLE, pointer port 0.
- Accept in cycle T; CHECK in T+1.
- Good result: WAIT covers T+2..T+1+ADD_LAT; rsp_valid in T+2+ADD_LAT.
- REJECT/degraded FAIL: rsp_valid in T+2.
- Each retry adds ADD_LAT cycles.
- Next accept is possible in the cycle after RESP, at the earliest.
- req_ready is asserted only in IDLE.
- A requester may drop req_valid without acceptance; nothing is latched.
- Reset mid-operation: the operation is discarded, no response is issued, and all outputs return to reset values immediately.

## Test plan
- Port0 A=3 B=2 par=0 op=001, adder model correct, ADD_LAT=1 -> rsp_valid[0] at T+3, sum=5, cout=0, status 00.
- Port1 A=3 B=2 par=0 op=010 -> sum=1, cout=1, status 00. Same operands with par=1 -> status 01 at T+2, add_en never high.
- Both ports valid every cycle from reset -> grants alternate 0,1,0,1; each response goes to the matching rsp_valid bit.
- Adder returns err 2'b00 once then 2'b10 -> status 00, err_cnt=1, response delayed by ADD_LAT. Err 2'b00 on three samples -> status 10, fault=1, err_cnt=3.
- With fault=1, a valid request -> status 10 at T+2 with no add_en. Pulse clr_fault -> fault=0; the next request completes with OK.
- Assert rst_n low during WAIT -> all outputs go to reset values, no rsp_valid; after release, the arbiter grants port 0 first.
